// File: rtl/d_sync_debounce.sv
// rtl/d_sync_debounce.sv - synchronizer plus debouncer with edge pulses and glitch counter
// Optional rise/fall edge registers are compiled in when D_SYNC_DEBOUNCE_EDGE_EN is defined.
module d_sync_debounce #(
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       d,
    output logic       q,
    output logic       q_bar,
    output logic       rise,
    output logic       fall,
    output logic       pending,
    output logic [7:0] glitch_cnt
);

    localparam int CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic [CNT_W-1:0]       cnt;
    logic                   q_r;
    logic [7:0]             glitch_r;
    logic                   accept;

    assign s      = sync_q[SYNC_STAGES-1];
    assign accept = (s != q_r) && (cnt == CNT_MAX);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d};
        end
    end

    // A candidate that falls back to q before reaching CNT_MAX counts as a glitch.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt      <= '0;
            q_r      <= 1'b0;
            glitch_r <= 8'd0;
        end else if (s == q_r) begin
            cnt <= '0;
            if ((cnt != '0) && (glitch_r != 8'd255)) begin
                glitch_r <= glitch_r + 8'd1;
            end
        end else if (accept) begin
            q_r <= s;
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

`ifdef D_SYNC_DEBOUNCE_EDGE_EN
    logic rise_r;
    logic fall_r;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rise_r <= 1'b0;
            fall_r <= 1'b0;
        end else begin
            rise_r <= accept && s;
            fall_r <= accept && !s;
        end
    end

    assign rise = rise_r;
    assign fall = fall_r;
`else
    assign rise = 1'b0;
    assign fall = 1'b0;
`endif

    assign q          = q_r;
    assign q_bar      = ~q_r;
    assign pending    = (cnt != '0);
    assign glitch_cnt = glitch_r;

endmodule

// File: tb/tb_d_sync_debounce.sv
// tb/tb_d_sync_debounce.sv - scoreboard bench for d_sync_debounce with directed vectors
module tb_d_sync_debounce;

`ifdef D_SYNC_DEBOUNCE_EDGE_EN
    localparam logic EDGE = 1'b1;
`else
    localparam logic EDGE = 1'b0;
`endif
    localparam logic [3:0] ALL = 4'b1111;
    localparam logic [3:0] QRF = 4'b1110;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       d = 1'b0;
    logic       q, q_bar, rise, fall, pending;
    logic [7:0] glitch_cnt;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        string      nm;
        logic [3:0] exp;
        logic [3:0] msk;
        int         g;
    } item_t;

    item_t sbq[$];

    d_sync_debounce #(.SYNC_STAGES(2), .DB_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .d(d), .q(q), .q_bar(q_bar), .rise(rise),
        .fall(fall), .pending(pending), .glitch_cnt(glitch_cnt)
    );

    always #5 clk = ~clk;

    // exp/msk bit order: {q, rise, fall, pending}; g < 0 means glitch_cnt not checked
    task automatic cyc(input logic dv, input logic rv, input logic [3:0] exp,
                       input logic [3:0] msk, input int g, input string nm);
        item_t it;
        @(negedge clk);
        d = dv;
        rst_n = rv;
        it.nm = nm;
        it.exp = exp & {1'b1, EDGE, EDGE, 1'b1};
        it.msk = msk;
        it.g = g;
        sbq.push_back(it);
    endtask

    initial begin : monitor
        item_t it;
        logic [3:0] act;
        forever begin
            @(posedge clk);
            #1;
            if (sbq.size() > 0) begin
                it = sbq.pop_front();
                act = {q, rise, fall, pending};
                vectors++;
                if ((((act ^ it.exp) & it.msk) != 4'b0) || (q_bar !== ~q) ||
                    ((it.g >= 0) && (int'(glitch_cnt) != it.g))) begin
                    miscompares++;
                    $display("FAIL %s: got q/rise/fall/pend=%b q_bar=%b glitch=%0d, want %b (mask %b) glitch=%0d",
                             it.nm, act, q_bar, glitch_cnt, it.exp, it.msk, it.g);
                end
            end
        end
    end

    initial begin : stim
        int gexp;
        logic dq [0:46];
        logic qk, qp;

        for (int k = 0; k < 3; k++) cyc(1'b1, 1'b0, 4'b0000, ALL, 0, "reset_hold");
        for (int k = 1; k <= 7; k++)
            cyc(1'b1, 1'b1, {k >= 6, k == 6, 1'b0, (k >= 3) && (k <= 5)}, ALL, 0, "rst_release");

        // falling candidate interrupted by reset
        for (int k = 1; k <= 4; k++) cyc(1'b0, 1'b1, {1'b1, 1'b0, 1'b0, k >= 3}, ALL, 0, "fall_pend");
        cyc(1'b0, 1'b0, 4'b0000, ALL, 0, "rst_mid_count");
        for (int k = 0; k < 8; k++) cyc(1'b0, 1'b1, 4'b0000, ALL, 0, "post_rst");

        for (int k = 1; k <= 7; k++)
            cyc(1'b1, 1'b1, {k >= 6, k == 6, 1'b0, (k >= 3) && (k <= 5)}, ALL, 0, "rise_seq");
        for (int k = 1; k <= 7; k++)
            cyc(1'b0, 1'b1, {k < 6, 1'b0, k == 6, (k >= 3) && (k <= 5)}, ALL, 0, "fall_seq");

        for (int k = 1; k <= 8; k++)
            cyc(k <= 2, 1'b1, {1'b0, 1'b0, 1'b0, (k == 3) || (k == 4)}, ALL, (k >= 5) ? 1 : 0, "glitch_2cyc");

        for (int i = 0; i < 300; i++) begin
            for (int c = 1; c <= 6; c++) begin
                gexp = (c == 6) ? 2 + i : 1 + i;
                if (gexp > 255) gexp = 255;
                cyc(c <= 3, 1'b1, {1'b0, 1'b0, 1'b0, (c >= 3) && (c <= 5)}, ALL, gexp, "glitch_sat");
            end
        end
        cyc(1'b0, 1'b1, 4'b0000, ALL, 255, "sat_hold");
        cyc(1'b0, 1'b0, 4'b0000, ALL, 0, "rst_clear_glitch");

        // d toggles every 10 cycles; q follows d five cycles later
        dq[0] = 1'b0;
        for (int k = 1; k <= 46; k++) dq[k] = (k <= 40) && ((((k - 1) / 10) % 2) == 0);
        qp = 1'b0;
        for (int k = 1; k <= 46; k++) begin
            qk = (k > 5) ? dq[k-5] : 1'b0;
            cyc(dq[k], 1'b1, {qk, qk & ~qp, ~qk & qp, 1'b0}, QRF, 0, "toggle");
            qp = qk;
        end

        for (int k = 0; k < 10 && sbq.size() > 0; k++) @(posedge clk);
        #2;
        if (sbq.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d items left, want 0", sbq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
